// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence tracking and lock detection FSM.
// Optional saturating error counter built only when JOHNSON_DECODER_ERRCNT_EN is defined.
module johnson_decoder #(
  parameter int N        = 3,
  parameter int LOCK_CNT = 2,
  localparam int IW      = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  output logic [IW-1:0] index,
  output logic          idx_valid,
  output logic          illegal,
  output logic          seq_err,
  output logic          locked,
  output logic [7:0]    err_count
);

  localparam int unsigned NU = N;

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_run, w_run_nx;
  logic          r_prev_vld, w_prev_vld_nx;
  logic [IW-1:0] r_prev, w_prev_nx;
  logic [IW-1:0] r_index, w_index_nx;
  logic          r_idx_valid, w_idx_valid_nx;
  logic          r_illegal, w_illegal_nx;
  logic          r_seq_err, w_seq_err_nx;

  logic          w_legal;
  logic [IW-1:0] w_dec_idx;
  logic [IW-1:0] w_exp_idx;
  logic          w_in_seq;
  logic [3:0]    w_run_inc;

  // Position k: first k MSBs set (k <= N), else the top (k-N) MSBs clear and the rest set.
  function automatic logic [N-1:0] jc_pattern(input int unsigned k);
    logic [N-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (k <= NU) p[i] = (i >= NU - k);
      else         p[i] = (i < 2 * NU - k);
    end
    return p;
  endfunction

  always_comb begin
    w_legal   = 1'b0;
    w_dec_idx = '0;
    for (int unsigned k = 0; k < 2 * NU; k++) begin
      if (code_in == jc_pattern(k)) begin
        w_legal   = 1'b1;
        w_dec_idx = IW'(k);
      end
    end
  end

  assign w_exp_idx = (r_prev == IW'(2 * N - 1)) ? '0 : r_prev + 1'b1;
  assign w_in_seq  = r_prev_vld && (w_dec_idx == w_exp_idx);
  assign w_run_inc = (w_in_seq && (r_run != 4'd0)) ? r_run + 4'd1 : 4'd1;

  always_comb begin
    w_state_nx     = r_state;
    w_run_nx       = r_run;
    w_prev_vld_nx  = r_prev_vld;
    w_prev_nx      = r_prev;
    w_index_nx     = r_index;
    w_idx_valid_nx = 1'b0;
    w_illegal_nx   = 1'b0;
    w_seq_err_nx   = 1'b0;
    if (code_valid) begin
      if (!w_legal) begin
        w_illegal_nx  = 1'b1;
        w_state_nx    = UNLOCKED;
        w_run_nx      = 4'd0;
        w_prev_vld_nx = 1'b0;
      end else begin
        w_idx_valid_nx = 1'b1;
        w_index_nx     = w_dec_idx;
        w_prev_nx      = w_dec_idx;
        w_prev_vld_nx  = 1'b1;
        case (r_state)
          UNLOCKED: begin
            w_run_nx = w_run_inc;
            // >= so a re-entry with run=1 still locks immediately when LOCK_CNT=1
            if (w_run_inc >= 4'(LOCK_CNT)) w_state_nx = LOCKED;
          end
          LOCKED: begin
            if (!w_in_seq) begin
              w_seq_err_nx = 1'b1;
              w_state_nx   = UNLOCKED;
              w_run_nx     = 4'd1;
            end
          end
          default: w_state_nx = UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= UNLOCKED;
      r_run       <= '0;
      r_prev_vld  <= 1'b0;
      r_prev      <= '0;
      r_index     <= '0;
      r_idx_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_run       <= w_run_nx;
      r_prev_vld  <= w_prev_vld_nx;
      r_prev      <= w_prev_nx;
      r_index     <= w_index_nx;
      r_idx_valid <= w_idx_valid_nx;
      r_illegal   <= w_illegal_nx;
      r_seq_err   <= w_seq_err_nx;
    end
  end

`ifdef JOHNSON_DECODER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Counts alongside the pulse it belongs to, so the count and the pulse appear together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if ((w_illegal_nx || w_seq_err_nx) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`else
  assign err_count = '0;
`endif

  assign index     = r_index;
  assign idx_valid = r_idx_valid;
  assign illegal   = r_illegal;
  assign seq_err   = r_seq_err;
  assign locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed table-driven bench for johnson_decoder (N=3, LOCK_CNT=2).
module tb_johnson_decoder;

  logic       clk;
  logic       rst;
  logic [2:0] code_in;
  logic       code_valid;
  logic [2:0] index;
  logic       idx_valid;
  logic       illegal;
  logic       seq_err;
  logic       locked;
  logic [7:0] err_count;

  int n_checks;
  int n_errs;
  int exp_err;

  johnson_decoder #(.N(3), .LOCK_CNT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_valid(code_valid),
    .index     (index),
    .idx_valid (idx_valid),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .locked    (locked),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] code;
    logic [2:0] idx;
    logic       iv;
    logic       ill;
    logic       seq;
    logic       lck;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic v, input logic [2:0] code, input logic [2:0] idx,
                              input logic iv, input logic ill, input logic seq, input logic lck);
    vec_t t;
    t.v = v; t.code = code; t.idx = idx; t.iv = iv; t.ill = ill; t.seq = seq; t.lck = lck;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [2:0] c);
    @(negedge clk);
    code_valid = v;
    code_in    = c;
    @(posedge clk);
    #1;
  endtask

  function automatic int bump(input int e);
`ifdef JOHNSON_DECODER_ERRCNT_EN
    return (e >= 255) ? 255 : e + 1;
`else
    return 0;
`endif
  endfunction

  task automatic check_all_clear(input string tag);
    check({tag, "_index"},  int'(index),     0);
    check({tag, "_iv"},     int'(idx_valid), 0);
    check({tag, "_ill"},    int'(illegal),   0);
    check({tag, "_seq"},    int'(seq_err),   0);
    check({tag, "_lock"},   int'(locked),    0);
    check({tag, "_errcnt"}, int'(err_count), 0);
  endtask

  initial begin
    n_checks   = 0;
    n_errs     = 0;
    exp_err    = 0;
    rst        = 1'b1;
    code_valid = 1'b0;
    code_in    = 3'b000;

    //            v  code    idx  iv ill seq lck
    vecs[0]  = mk(1, 3'b000, 3'd0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 3'b100, 3'd1, 1, 0, 0, 1);
    vecs[2]  = mk(1, 3'b110, 3'd2, 1, 0, 0, 1);
    vecs[3]  = mk(1, 3'b111, 3'd3, 1, 0, 0, 1);
    vecs[4]  = mk(1, 3'b011, 3'd4, 1, 0, 0, 1);
    vecs[5]  = mk(1, 3'b001, 3'd5, 1, 0, 0, 1);
    vecs[6]  = mk(1, 3'b000, 3'd0, 1, 0, 0, 1);
    vecs[7]  = mk(1, 3'b100, 3'd1, 1, 0, 0, 1);
    vecs[8]  = mk(1, 3'b110, 3'd2, 1, 0, 0, 1);
    vecs[9]  = mk(1, 3'b011, 3'd4, 1, 0, 1, 0);
    vecs[10] = mk(1, 3'b001, 3'd5, 1, 0, 0, 1);
    vecs[11] = mk(1, 3'b101, 3'd5, 0, 1, 0, 0);
    vecs[12] = mk(1, 3'b000, 3'd0, 1, 0, 0, 0);
    vecs[13] = mk(1, 3'b100, 3'd1, 1, 0, 0, 1);
    vecs[14] = mk(0, 3'b111, 3'd1, 0, 0, 0, 1);
    vecs[15] = mk(0, 3'b010, 3'd1, 0, 0, 0, 1);
    vecs[16] = mk(0, 3'b000, 3'd1, 0, 0, 0, 1);
    vecs[17] = mk(0, 3'b101, 3'd1, 0, 0, 0, 1);
    vecs[18] = mk(0, 3'b011, 3'd1, 0, 0, 0, 1);
    vecs[19] = mk(1, 3'b110, 3'd2, 1, 0, 0, 1);
    vecs[20] = mk(1, 3'b110, 3'd2, 1, 0, 1, 0);
    vecs[21] = mk(1, 3'b010, 3'd2, 0, 1, 0, 0);
    vecs[22] = mk(1, 3'b111, 3'd3, 1, 0, 0, 0);
    vecs[23] = mk(1, 3'b011, 3'd4, 1, 0, 0, 1);
    vecs[24] = mk(1, 3'b001, 3'd5, 1, 0, 0, 1);

    #12;
    check_all_clear("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      apply(vecs[i].v, vecs[i].code);
      if (vecs[i].ill || vecs[i].seq) exp_err = bump(exp_err);
      check($sformatf("v%0d_index", i),  int'(index),     int'(vecs[i].idx));
      check($sformatf("v%0d_iv", i),     int'(idx_valid), int'(vecs[i].iv));
      check($sformatf("v%0d_ill", i),    int'(illegal),   int'(vecs[i].ill));
      check($sformatf("v%0d_seq", i),    int'(seq_err),   int'(vecs[i].seq));
      check($sformatf("v%0d_lock", i),   int'(locked),    int'(vecs[i].lck));
      check($sformatf("v%0d_errcnt", i), int'(err_count), exp_err);
    end

    // Saturation: 300 consecutive illegal samples
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 3'b010);
      exp_err = bump(exp_err);
      check("sat_ill", int'(illegal), 1);
      check("sat_seq", int'(seq_err), 0);
    end
    check("sat_errcnt", int'(err_count), exp_err);
    check("sat_lock",   int'(locked),    0);
    check("sat_index",  int'(index),     5);

    // Relock after illegal run
    apply(1'b1, 3'b000);
    check("relock0_lock", int'(locked), 0);
    apply(1'b1, 3'b100);
    check("relock1_lock",  int'(locked), 1);
    check("relock1_index", int'(index),  1);

    // Asynchronous reset between clock edges while locked
    apply(1'b1, 3'b110);
    check("pre_rst_lock",  int'(locked), 1);
    check("pre_rst_index", int'(index),  2);
    #2;
    rst = 1'b1;
    #1;
    check_all_clear("async_rst");
    code_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Fresh start: history from before reset must not count
    apply(1'b1, 3'b111);
    check("fresh0_index", int'(index),   3);
    check("fresh0_lock",  int'(locked),  0);
    check("fresh0_seq",   int'(seq_err), 0);
    apply(1'b1, 3'b011);
    check("fresh1_lock",  int'(locked),  1);
    check("fresh1_index", int'(index),   4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
